// File: rtl/seq_multiplier.sv
// Sequential 8x8 unsigned shift-add multiplier with a 16-bit product.
// One add-and-shift per clock through the shared 8-bit full_adder, so a
// product takes a fixed 8 iterations after the start is accepted.
//
// Handshake: start is sampled on the rising edge and accepted only while
// busy=0. busy is high for the 8 iteration cycles. done pulses high for one
// cycle when the product register is updated, and product holds until the
// next completion.

module full_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   // 9-bit add so the carry-out lands in the top bit
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'h00, cin};

endmodule

module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
   logic [2:0]         cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [WIDTH-1:0]   fa_b;
   logic [WIDTH-1:0]   fa_sum;
   logic               fa_cout;

   // Add M into the high half only when the current multiplier bit is set
   assign fa_b = acc_lo_q[0] ? m_q : '0;

   full_adder u_full_adder (
      .a    (acc_hi_q),
      .b    (fa_b),
      .cin  (1'b0),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Next-state logic: accept a start in IDLE, add-and-shift in CALC
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               m_d      = multiplicand;
               acc_lo_d = multiplier;
               acc_hi_d = '0;
               cnt_d    = 3'd0;
               state_d  = CALC;
            end
         end
         CALC: begin
            // 17-bit right shift of {cout, sum, acc_lo}; the carry becomes the new MSB
            acc_hi_d = {fa_cout, fa_sum[WIDTH-1:1]};
            acc_lo_d = {fa_sum[0], acc_lo_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               product_d = {acc_hi_d, acc_lo_d};
               done_d    = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation without a done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_q       <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         cnt_q     <= 3'd0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == CALC);
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier. Inputs change on the falling edge and
// outputs are sampled on the falling edge. Expected products come from a
// plain multiply and are queued when an operation is launched, then popped
// when done is seen.

module tb_seq_multiplier;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        busy;
   logic        done;
   logic [15:0] product;

   logic [15:0] exp_q[$];
   logic [15:0] last_prod;
   int          checks;
   int          failures;

   seq_multiplier #(.WIDTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   // Clock: 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_mul(input logic [7:0] m, input logic [7:0] q);
      logic [15:0] a;
      logic [15:0] b;
      a = {8'h00, m};
      b = {8'h00, q};
      return a * b;
   endfunction

   // Drive one start pulse; returns on the falling edge after the accepting edge
   task automatic launch(input logic [7:0] m, input logic [7:0] q);
      @(negedge clk);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      exp_q.push_back(model_mul(m, q));
      @(negedge clk);
      start        = 1'b0;
      multiplicand = 8'h00;
      multiplier   = 8'h00;
   endtask

   // Check n busy cycles (no done, product held), advancing one cycle per sample
   task automatic expect_calc(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_busy"}, {15'b0, busy}, 16'h0001);
         check({tag, "_nodone"}, {15'b0, done}, 16'h0000);
         check({tag, "_hold"}, product, last_prod);
         @(negedge clk);
      end
   endtask

   // Bounded wait for done, compare against the scoreboard, then check the pulse ends
   task automatic expect_done(input string tag);
      int k;
      logic [15:0] exp;
      k = 0;
      while (done !== 1'b1 && k < 16) begin
         @(negedge clk);
         k++;
      end
      if (done !== 1'b1) begin
         check({tag, "_done_timeout"}, {15'b0, done}, 16'h0001);
      end else begin
         if (exp_q.size() == 0) begin
            check({tag, "_unexpected_done"}, 16'(exp_q.size()), 16'h0001);
         end else begin
            exp = exp_q.pop_front();
            check({tag, "_product"}, product, exp);
            last_prod = exp;
         end
         check({tag, "_idle_at_done"}, {15'b0, busy}, 16'h0000);
         @(negedge clk);
         check({tag, "_done_pulse_end"}, {15'b0, done}, 16'h0000);
      end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      last_prod    = 16'h0000;
      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = 8'h00;
      multiplier   = 8'h00;

      // Reset state
      #2;
      check("reset_busy", {15'b0, busy}, 16'h0000);
      check("reset_done", {15'b0, done}, 16'h0000);
      check("reset_product", product, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Basic operation, 8 busy cycles then one done
      launch(8'hAA, 8'hCC);
      expect_calc("aa_cc", 8);
      expect_done("aa_cc");
      check("aa_cc_idle_after", {15'b0, busy}, 16'h0000);

      // Back-to-back with start held high through completion
      @(negedge clk);
      multiplicand = 8'hFF;
      multiplier   = 8'hFF;
      start        = 1'b1;
      exp_q.push_back(model_mul(8'hFF, 8'hFF));
      exp_q.push_back(model_mul(8'hFF, 8'hFF));
      @(negedge clk);
      expect_calc("b2b_first", 8);
      expect_done("b2b_first");
      start = 1'b0;
      expect_calc("b2b_second", 7);
      expect_done("b2b_second");

      // Operand mix
      launch(8'h7B, 8'hA5);
      expect_calc("7b_a5", 8);
      expect_done("7b_a5");
      launch(8'h00, 8'h5A);
      expect_calc("00_5a", 8);
      expect_done("00_5a");
      launch(8'h01, 8'h80);
      expect_calc("01_80", 8);
      expect_done("01_80");

      // Start while busy is ignored
      launch(8'h55, 8'h56);
      expect_calc("busy_ign", 2);
      multiplicand = 8'h12;
      multiplier   = 8'h34;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      multiplicand = 8'h00;
      multiplier   = 8'h00;
      expect_calc("busy_ign_rest", 5);
      expect_done("busy_ign");
      for (int i = 0; i < 12; i++) begin
         check("busy_ign_single_done", {15'b0, done}, 16'h0000);
         @(negedge clk);
      end
      check("busy_ign_queue_empty", 16'(exp_q.size()), 16'h0000);

      // Reset mid-operation aborts with no done
      launch(8'hFF, 8'h02);
      expect_calc("rst_mid", 3);
      rst_n = 1'b0;
      exp_q.delete();
      last_prod = 16'h0000;
      #1;
      check("rst_mid_busy", {15'b0, busy}, 16'h0000);
      check("rst_mid_product", product, 16'h0000);
      check("rst_mid_done", {15'b0, done}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("rst_mid_no_done", {15'b0, done}, 16'h0000);
         @(negedge clk);
      end
      launch(8'h03, 8'h04);
      expect_calc("after_rst", 8);
      expect_done("after_rst");

      // Carry out of the adder must enter the accumulator
      launch(8'hFF, 8'h03);
      expect_calc("carry", 8);
      expect_done("carry");

      check("final_queue_empty", 16'(exp_q.size()), 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Sequential 8x8 unsigned shift-add multiplier that produces a 16-bit product.
- Sits directly upstream of the 8-bit full_adder: it drives the adder's A, B and cin every iteration and consumes its sum and cout.
- It is the ALU's multiply path and reuses the adder rather than adding a second carry chain.
- Start/busy/done handshake; fixed 8-iteration latency.

Parameters:
- WIDTH, 8, operand width. Fixed at 8 to match full_adder; any other value is unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled on the rising edge; honoured only while busy=0.
- multiplicand  input  8  operand M; captured on the accepted start.
- multiplier  input  8  operand Q; captured on the accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product is valid from this cycle onward.
- product  output  16  registered result; held until the next completion.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n.
- During reset: state=IDLE, busy=0, done=0, product=16'h0000, counter=0, internal registers cleared.
- Internal registers: M[7:0], acc_hi[7:0], acc_lo[7:0], cnt[2:0].
- Instantiates full_adder with:
  - A = acc_hi
  - B = acc_lo[0] ? M : 8'h00
  - cin = 0
- States:
  - IDLE:
    - busy=0.
    - On an edge with start=1: M<=multiplicand, acc_lo<=multiplier, acc_hi<=0, cnt<=0, go to CALC.
    - start=0: stay in IDLE.
  - CALC:
    - busy=1.
    - Each edge: {acc_hi,acc_lo} <= {cout, sum, acc_lo[7:1]}, i.e. a 17-bit right shift of {cout,sum,acc_lo}. cnt<=cnt+1.
    - When cnt==7 at the edge: product <= the shifted {acc_hi,acc_lo} value, done<=1, go to IDLE.
- Latency:
  - Start accepted at edge N.
  - Iterations occur on edges N+1 through N+8.
  - busy is high from after edge N until after edge N+8.
  - done is high for exactly the one cycle following edge N+8.
- done is deasserted on every edge where completion does not occur.
- start while busy=1: ignored. Operands and the running computation are unaffected.
- start on the cycle done=1: accepted (busy=0 by then). The new operation begins and product keeps its old value until the new completion.
- cout of the adder is never dropped: it becomes bit 15 of the shifted accumulator. The maximum product 0xFE01 fits without overflow.
- Operand inputs are don't-care except on the edge where start is accepted.
- Reset asserted mid-CALC: immediately aborts to IDLE, clears product to 0, and produces no done pulse. After reset is released, a new start behaves normally.
- Zero operands need no special case: the full 8 iterations always run.

Test Plan:
- Reset, then start with M=0xAA, Q=0xCC -> busy high for 8 cycles, then a single done pulse with product=0x8778.
- Back-to-back: M=0xFF, Q=0xFF, with start held high through completion -> product=0xFE01 on the first done. The second operation auto-starts the cycle done=1 and completes 8 cycles later with product=0xFE01 again; product stays 0xFE01 throughout.
- Operand mix: M=0x7B, Q=0xA5 -> product=0x4F47. M=0x00, Q=0x5A -> product=0x0000 after 8 cycles. M=0x01, Q=0x80 -> product=0x0080.
- Start while busy: start M=0x55, Q=0x56, then pulse start with M=0x12, Q=0x34 at cycle 3 of CALC -> second request ignored; product=0x1C8E and exactly one done pulse.
- Reset mid-op: start M=0xFF, Q=0x02, assert rst_n=0 at CALC cycle 4 -> busy=0, product=0, no done. Release and start M=0x03, Q=0x04 -> product=0x000C.
- Carry path: M=0xFF, Q=0x03 (sum overflows on the second iteration) -> product=0x02FD, confirming cout is captured into the accumulator.
